// File: rtl/dec_stage_if.sv
// Fetch-to-execute bus of the decode stage: fetch handshake in, execute control bus out.
interface dec_stage_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [31:0]       in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              in_ready;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic              regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch;
  logic [2:0]        alusig;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   br_target, j_target, out_pc;
  logic              illegal;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, regdst, regwr, extop, alusrc, memwr, memtoreg,
           jump, branch, alusig, rs, rt, rd, imm, br_target, j_target, out_pc,
           illegal, bubble_cnt
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, regdst, regwr, extop, alusrc, memwr, memtoreg,
           jump, branch, alusig, rs, rt, rd, imm, br_target, j_target, out_pc,
           illegal, bubble_cnt
  );
endinterface

// File: rtl/dec_stage.sv
// MIPS decode stage: decodes one instruction per transfer into a valid/ready output
// register, with a one-bubble load-use interlock, flush and a saturating bubble counter.
module dec_stage #(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  dec_stage_if.slave bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [5:0] opcode, funct;
  logic [4:0] in_rs, in_rt, in_rd;
  assign opcode = bus.in_inst[31:26];
  assign funct  = bus.in_inst[5:0];
  assign in_rs  = bus.in_inst[25:21];
  assign in_rt  = bus.in_inst[20:16];
  assign in_rd  = bus.in_inst[15:11];

  logic       regdst_d, regwr_d, extop_d, alusrc_d, memwr_d, memtoreg_d, jump_d, branch_d;
  logic [2:0] alusig_d;
  logic       illegal_d;

  always_comb begin
    regdst_d   = 1'b0;
    regwr_d    = 1'b0;
    extop_d    = 1'b0;
    alusrc_d   = 1'b0;
    memwr_d    = 1'b0;
    memtoreg_d = 1'b0;
    jump_d     = 1'b0;
    branch_d   = 1'b0;
    alusig_d   = 3'd0;
    illegal_d  = 1'b0;
    case (opcode)
      OP_R: begin
        regdst_d = 1'b1;
        regwr_d  = 1'b1;
        case (funct)
          6'b100000: alusig_d = 3'd0;
          6'b100010: alusig_d = 3'd1;
          6'b100100: alusig_d = 3'd2;
          6'b100101: alusig_d = 3'd3;
          6'b101010: alusig_d = 3'd6;
          default: begin
            regdst_d  = 1'b0;
            regwr_d   = 1'b0;
            illegal_d = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin regwr_d = 1'b1; extop_d = 1'b1; alusrc_d = 1'b1; alusig_d = 3'd0; end
      OP_ANDI: begin regwr_d = 1'b1; alusrc_d = 1'b1; alusig_d = 3'd2; end
      OP_ORI:  begin regwr_d = 1'b1; alusrc_d = 1'b1; alusig_d = 3'd3; end
      OP_SLTI: begin regwr_d = 1'b1; extop_d = 1'b1; alusrc_d = 1'b1; alusig_d = 3'd6; end
      OP_LW: begin
        regwr_d = 1'b1; extop_d = 1'b1; alusrc_d = 1'b1; memtoreg_d = 1'b1; alusig_d = 3'd0;
      end
      OP_SW:   begin memwr_d = 1'b1; extop_d = 1'b1; alusrc_d = 1'b1; alusig_d = 3'd0; end
      OP_BEQ:  begin branch_d = 1'b1; extop_d = 1'b1; alusig_d = 3'd1; end
      OP_J:    jump_d = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  logic [PC_W-1:0]   pc4, br_target_d, j_target_d;
  logic [DATA_W-1:0] imm_d;
  assign pc4         = bus.in_pc + PC_W'(4);
  assign br_target_d = pc4 + (PC_W'($signed(bus.in_inst[15:0])) << 2);
  assign imm_d       = extop_d ? DATA_W'($signed(bus.in_inst[15:0]))
                               : DATA_W'(bus.in_inst[15:0]);

  // With a 28-bit PC the jump target has no region bits above the 26-bit index.
  generate
    if (PC_W > 28) begin : g_jregion
      assign j_target_d = {pc4[PC_W-1:28], bus.in_inst[25:0], 2'b00};
    end else begin : g_jflat
      assign j_target_d = {bus.in_inst[25:0], 2'b00};
    end
  endgenerate

  logic              out_valid_q;
  logic              regdst_q, regwr_q, extop_q, alusrc_q, memwr_q, memtoreg_q, jump_q, branch_q;
  logic [2:0]        alusig_q;
  logic              illegal_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [PC_W-1:0]   br_target_q, j_target_q, out_pc_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  // Only a held lw (the sole memtoreg producer) can cause a load-use stall.
  logic uses_rs, uses_rt, hazard, in_ready, take;
  assign uses_rs  = (opcode != OP_J);
  assign uses_rt  = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign hazard   = HAZARD_EN && bus.in_valid && out_valid_q && memtoreg_q && (rt_q != 5'd0)
                    && ((uses_rs && (rt_q == in_rs)) || (uses_rt && (rt_q == in_rt)));
  assign in_ready = bus.flush || ((!out_valid_q || bus.out_ready) && !hazard);
  assign take     = bus.in_valid && in_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      regdst_q     <= 1'b0;
      regwr_q      <= 1'b0;
      extop_q      <= 1'b0;
      alusrc_q     <= 1'b0;
      memwr_q      <= 1'b0;
      memtoreg_q   <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alusig_q     <= 3'd0;
      illegal_q    <= 1'b0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      rd_q         <= 5'd0;
      imm_q        <= '0;
      br_target_q  <= '0;
      j_target_q   <= '0;
      out_pc_q     <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (take) begin
      out_valid_q <= 1'b1;
      regdst_q    <= regdst_d;
      regwr_q     <= regwr_d;
      extop_q     <= extop_d;
      alusrc_q    <= alusrc_d;
      memwr_q     <= memwr_d;
      memtoreg_q  <= memtoreg_d;
      jump_q      <= jump_d;
      branch_q    <= branch_d;
      alusig_q    <= alusig_d;
      illegal_q   <= illegal_d;
      rs_q        <= in_rs;
      rt_q        <= in_rt;
      rd_q        <= in_rd;
      imm_q       <= imm_d;
      br_target_q <= br_target_d;
      j_target_q  <= j_target_d;
      out_pc_q    <= bus.in_pc;
    end else if (hazard && bus.out_ready) begin
      out_valid_q <= 1'b0;
      if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.regdst     = regdst_q;
  assign bus.regwr      = regwr_q;
  assign bus.extop      = extop_q;
  assign bus.alusrc     = alusrc_q;
  assign bus.memwr      = memwr_q;
  assign bus.memtoreg   = memtoreg_q;
  assign bus.jump       = jump_q;
  assign bus.branch     = branch_q;
  assign bus.alusig     = alusig_q;
  assign bus.illegal    = illegal_q;
  assign bus.rs         = rs_q;
  assign bus.rt         = rt_q;
  assign bus.rd         = rd_q;
  assign bus.imm        = imm_q;
  assign bus.br_target  = br_target_q;
  assign bus.j_target   = j_target_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed scenarios on an interlocked and a non-interlocked instance,
// then random traffic scored against a rule-level reference model.
module tb_dec_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_stage_if #(.PC_W(32), .DATA_W(32), .CNT_W(3))  ifa ();
  dec_stage_if #(.PC_W(32), .DATA_W(32), .CNT_W(16)) ifb ();

  dec_stage #(.PC_W(32), .DATA_W(32), .CNT_W(3), .HAZARD_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dec_stage #(.PC_W(32), .DATA_W(32), .CNT_W(16), .HAZARD_EN(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_inst   = ifa.in_inst;
  assign ifb.in_pc     = ifa.in_pc;
  assign ifb.flush     = ifa.flush;
  assign ifb.out_ready = ifa.out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch;
    logic [2:0]  alusig;
    logic        illegal;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, br, jt, pc;
  } exp_t;

  // Reference decode written straight from the instruction table.
  function automatic exp_t ref_decode(logic [31:0] inst, logic [31:0] pc);
    exp_t e = '0;
    logic [5:0] op = inst[31:26];
    logic [5:0] fn = inst[5:0];
    e.rs = inst[25:21]; e.rt = inst[20:16]; e.rd = inst[15:11]; e.pc = pc;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: e.alusig = 0;
          6'h22: e.alusig = 1;
          6'h24: e.alusig = 2;
          6'h25: e.alusig = 3;
          6'h2A: e.alusig = 6;
          default: e.illegal = 1;
        endcase
        if (!e.illegal) begin e.regdst = 1; e.regwr = 1; end
      end
      6'h08: begin e.regwr = 1; e.extop = 1; e.alusrc = 1; e.alusig = 0; end
      6'h0C: begin e.regwr = 1; e.alusrc = 1; e.alusig = 2; end
      6'h0D: begin e.regwr = 1; e.alusrc = 1; e.alusig = 3; end
      6'h0A: begin e.regwr = 1; e.extop = 1; e.alusrc = 1; e.alusig = 6; end
      6'h23: begin e.regwr = 1; e.extop = 1; e.alusrc = 1; e.memtoreg = 1; end
      6'h2B: begin e.memwr = 1; e.extop = 1; e.alusrc = 1; end
      6'h04: begin e.branch = 1; e.extop = 1; e.alusig = 1; end
      6'h02: e.jump = 1;
      default: e.illegal = 1;
    endcase
    e.imm = e.extop ? 32'($signed(inst[15:0])) : {16'h0000, inst[15:0]};
    e.br  = pc + 32'd4 + 32'($signed(inst[15:0])) * 32'd4;
    e.jt  = ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, inst[25:0]} * 32'd4);
    return e;
  endfunction

  logic m_valid [2];
  exp_t m_exp   [2];
  int   m_cnt   [2];

  function automatic logic ref_stall(int k, logic v, logic [31:0] inst);
    logic [5:0] op = inst[31:26];
    logic reads_rs, reads_rt;
    if (k != 0 || !v || !m_valid[k] || !m_exp[k].memtoreg || m_exp[k].rt == 5'd0) return 1'b0;
    reads_rs = (op != 6'h02);
    reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return (reads_rs && inst[25:21] == m_exp[k].rt) || (reads_rt && inst[20:16] == m_exp[k].rt);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] inst, logic [31:0] pc, logic ordy, logic fl);
    ifa.in_valid = v; ifa.in_inst = inst; ifa.in_pc = pc; ifa.out_ready = ordy; ifa.flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ifa.out_valid); end
    checks++; if (ifa.regwr !== 1'b0 || ifa.regdst !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %0b%0b exp 00", ifa.regwr, ifa.regdst); end
    checks++; if (ifa.imm !== 32'h0 || ifa.br_target !== 32'h0 || ifa.out_pc !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", ifa.imm, ifa.br_target, ifa.out_pc); end
    checks++; if (ifa.bubble_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ifa.bubble_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    drive(1'b1, 32'h00221820, 32'h40, 1'b1, 1'b0);
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b exp 1", ifa.in_ready); end
    step();
    checks++; if ({ifa.out_valid, ifa.regdst, ifa.regwr, ifa.alusig, ifa.illegal} !== 7'b1110000) begin errors++; $display("FAIL add_ctrl got %b exp 1110000", {ifa.out_valid, ifa.regdst, ifa.regwr, ifa.alusig, ifa.illegal}); end
    checks++; if ({ifa.rs, ifa.rt, ifa.rd} !== {5'd1, 5'd2, 5'd3} || ifa.out_pc !== 32'h40) begin errors++; $display("FAIL add_regs got %0d %0d %0d pc %h exp 1 2 3 pc 40", ifa.rs, ifa.rt, ifa.rd, ifa.out_pc); end
    $display("txn add pc=%h", ifa.out_pc);
    drive(1'b1, 32'h2045FFFF, 32'h44, 1'b1, 1'b0);
    step();
    checks++; if (ifa.imm !== 32'hFFFFFFFF || ifa.extop !== 1'b1 || ifa.alusrc !== 1'b1) begin errors++; $display("FAIL addi_imm got %h ext %0b exp ffffffff ext 1", ifa.imm, ifa.extop); end
    $display("txn addi pc=%h", ifa.out_pc);
    drive(1'b1, 32'h3445FFFF, 32'h48, 1'b1, 1'b0);
    step();
    checks++; if (ifa.imm !== 32'h0000FFFF || ifa.extop !== 1'b0 || ifa.alusig !== 3'd3) begin errors++; $display("FAIL ori_imm got %h ext %0b op %0d exp 0000ffff ext 0 op 3", ifa.imm, ifa.extop, ifa.alusig); end
    $display("txn ori pc=%h", ifa.out_pc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_branch_jump();
    drive(1'b1, 32'h10220003, 32'h100, 1'b1, 1'b0);
    step();
    checks++; if (ifa.branch !== 1'b1 || ifa.alusig !== 3'd1 || ifa.br_target !== 32'h110) begin errors++; $display("FAIL beq got br %0b op %0d tgt %h exp 1 1 00000110", ifa.branch, ifa.alusig, ifa.br_target); end
    $display("txn beq pc=%h", ifa.out_pc);
    drive(1'b1, 32'h08000040, 32'h00400000, 1'b1, 1'b0);
    step();
    checks++; if (ifa.jump !== 1'b1 || ifa.regwr !== 1'b0 || ifa.j_target !== 32'h100) begin errors++; $display("FAIL jump got j %0b wr %0b tgt %h exp 1 0 00000100", ifa.jump, ifa.regwr, ifa.j_target); end
    $display("txn j pc=%h", ifa.out_pc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFC000000, 32'h80, 1'b1, 1'b0);
    step();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.illegal !== 1'b1 || {ifa.regdst, ifa.regwr, ifa.extop, ifa.alusrc, ifa.memwr, ifa.memtoreg, ifa.jump, ifa.branch} !== 8'h00) begin errors++; $display("FAIL illegal_op got v %0b ill %0b ctrl %h exp 1 1 00", ifa.out_valid, ifa.illegal, {ifa.regdst, ifa.regwr, ifa.extop, ifa.alusrc, ifa.memwr, ifa.memtoreg, ifa.jump, ifa.branch}); end
    drive(1'b1, 32'h00221821, 32'h84, 1'b1, 1'b0);
    step();
    checks++; if (ifa.illegal !== 1'b1 || ifa.regdst !== 1'b0 || ifa.regwr !== 1'b0) begin errors++; $display("FAIL illegal_funct got ill %0b dst %0b wr %0b exp 1 0 0", ifa.illegal, ifa.regdst, ifa.regwr); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_hazard();
    drive(1'b1, 32'h8C220004, 32'h200, 1'b1, 1'b0);
    step();
    checks++; if (ifa.memtoreg !== 1'b1 || ifa.rt !== 5'd2) begin errors++; $display("FAIL lw_held got m2r %0b rt %0d exp 1 2", ifa.memtoreg, ifa.rt); end
    drive(1'b1, 32'h00441820, 32'h204, 1'b1, 1'b0);
    #1;
    checks++; if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b1) begin errors++; $display("FAIL haz_ready got a %0b b %0b exp 0 1", ifa.in_ready, ifb.in_ready); end
    step();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.bubble_cnt !== 3'd1) begin errors++; $display("FAIL haz_bubble got v %0b cnt %0d exp 0 1", ifa.out_valid, ifa.bubble_cnt); end
    checks++; if (ifb.out_valid !== 1'b1 || ifb.rd !== 5'd3 || ifb.bubble_cnt !== 16'd0) begin errors++; $display("FAIL nohaz_pass got v %0b rd %0d cnt %0d exp 1 3 0", ifb.out_valid, ifb.rd, ifb.bubble_cnt); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL haz_release got %0b exp 1", ifa.in_ready); end
    step();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.rd !== 5'd3 || ifa.out_pc !== 32'h204) begin errors++; $display("FAIL haz_accept got v %0b rd %0d pc %h exp 1 3 00000204", ifa.out_valid, ifa.rd, ifa.out_pc); end
    $display("txn add-after-lw pc=%h", ifa.out_pc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h00221820, 32'h300, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h3445FFFF, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b exp 0", i, ifa.in_ready); end
      step();
      checks++; if (ifa.out_valid !== 1'b1 || ifa.rd !== 5'd3 || ifa.imm !== 32'h1820 || ifa.out_pc !== 32'h300) begin errors++; $display("FAIL stall_hold[%0d] got v %0b rd %0d imm %h pc %h exp 1 3 00001820 00000300", i, ifa.out_valid, ifa.rd, ifa.imm, ifa.out_pc); end
    end
    drive(1'b1, 32'h2045FFFF, 32'h308, 1'b0, 1'b1);
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", ifa.in_ready); end
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %0b exp 0", ifa.out_valid); end
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b exp 0", ifa.out_valid); end
    drive(1'b1, 32'h8C220004, 32'h310, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h00441820, 32'h314, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (ifa.out_valid !== 1'b0 || ifa.bubble_cnt !== 3'd1) begin errors++; $display("FAIL flush_haz got v %0b cnt %0d exp 0 1", ifa.out_valid, ifa.bubble_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h8C220004, 32'h400, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h00441820, 32'h404, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (ifa.out_valid !== 1'b0 || ifa.regwr !== 1'b0 || ifa.rs !== 5'd0 || ifa.imm !== 32'h0 || ifa.out_pc !== 32'h0) begin errors++; $display("FAIL midrst_out got v %0b wr %0b rs %0d imm %h pc %h exp all 0", ifa.out_valid, ifa.regwr, ifa.rs, ifa.imm, ifa.out_pc); end
    checks++; if (ifa.bubble_cnt !== 3'd0 || ifb.bubble_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d %0d exp 0 0", ifa.bubble_cnt, ifb.bubble_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h8C220004, 32'h500, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h00441820, 32'h504, 1'b1, 1'b0);
      step(); step();
      if (i == 6) begin
        checks++; if (ifa.bubble_cnt !== 3'd7) begin errors++; $display("FAIL sat_reach got %0d exp 7", ifa.bubble_cnt); end
      end
    end
    checks++; if (ifa.bubble_cnt !== 3'd7 || ifb.bubble_cnt !== 16'd0) begin errors++; $display("FAIL sat_hold got %0d %0d exp 7 0", ifa.bubble_cnt, ifb.bubble_cnt); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                             6'h23, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h00};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 13);
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [4:0] rd = 5'($urandom_range(0, 3));
    logic [5:0] fn = (ops[sel] == 6'h00) ? fns[$urandom_range(0, 5)] : r[5:0];
    return {ops[sel], rs, rt, rd, r[10:6], fn};
  endfunction

  task automatic test_random();
    exp_t got [2];
    exp_t nxt;
    logic gready [2];
    logic gvalid [2];
    int   gcnt [2];
    logic eready, stall;
    logic [31:0] pcr;
    for (int c = 0; c < 600; c++) begin
      rst = (c == 0) || ($urandom_range(0, 63) == 0);
      pcr = $urandom;
      drive($urandom_range(0, 3) != 0, rand_inst(), pcr & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      #1;
      got[0] = {ifa.regdst, ifa.regwr, ifa.extop, ifa.alusrc, ifa.memwr, ifa.memtoreg, ifa.jump,
                ifa.branch, ifa.alusig, ifa.illegal, ifa.rs, ifa.rt, ifa.rd, ifa.imm,
                ifa.br_target, ifa.j_target, ifa.out_pc};
      got[1] = {ifb.regdst, ifb.regwr, ifb.extop, ifb.alusrc, ifb.memwr, ifb.memtoreg, ifb.jump,
                ifb.branch, ifb.alusig, ifb.illegal, ifb.rs, ifb.rt, ifb.rd, ifb.imm,
                ifb.br_target, ifb.j_target, ifb.out_pc};
      gready[0] = ifa.in_ready;  gready[1] = ifb.in_ready;
      gvalid[0] = ifa.out_valid; gvalid[1] = ifb.out_valid;
      gcnt[0] = int'(ifa.bubble_cnt); gcnt[1] = int'(ifb.bubble_cnt);
      for (int k = 0; k < 2; k++) begin
        stall  = ref_stall(k, ifa.in_valid, ifa.in_inst);
        eready = ifa.flush || ((!m_valid[k] || ifa.out_ready) && !stall);
        if (c > 0) begin
          checks++; if (gready[k] !== eready) begin errors++; $display("FAIL rand_ready[%0d] cyc %0d got %0b exp %0b", k, c, gready[k], eready); end
          checks++; if (gvalid[k] !== m_valid[k] || gcnt[k] != m_cnt[k]) begin errors++; $display("FAIL rand_state[%0d] cyc %0d got v %0b cnt %0d exp v %0b cnt %0d", k, c, gvalid[k], gcnt[k], m_valid[k], m_cnt[k]); end
          if (m_valid[k]) begin
            checks++; if (got[k] !== m_exp[k]) begin errors++; $display("FAIL rand_bus[%0d] cyc %0d got %h exp %h", k, c, got[k], m_exp[k]); end
          end
          if (k == 0 && m_valid[k] && ifa.out_ready && !rst) $display("txn rand cyc %0d pc=%h ill=%0b", c, m_exp[k].pc, m_exp[k].illegal);
        end
        if (rst) begin
          m_valid[k] = 1'b0; m_cnt[k] = 0; m_exp[k] = '0;
        end else if (ifa.flush) begin
          m_valid[k] = 1'b0;
        end else if (ifa.in_valid && eready) begin
          nxt = ref_decode(ifa.in_inst, ifa.in_pc);
          m_valid[k] = 1'b1; m_exp[k] = nxt;
        end else if (ifa.out_ready) begin
          if (stall) m_cnt[k] = (m_cnt[k] == (k == 0 ? 7 : 65535)) ? m_cnt[k] : m_cnt[k] + 1;
          m_valid[k] = 1'b0;
        end
      end
      step();
    end
    rst = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_alu();
    test_branch_jump();
    test_illegal();
    test_hazard();
    test_stall_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dec_stage.md
# dec_stage

Registered, parametrised instruction-decode stage for the pipelined MIPS core, sitting between fetch and execute. It decodes one 32-bit instruction per transfer into the execute control bus. It extends the immediate and precomputes branch and jump targets. It holds the result in a valid/ready output register, inserts one bubble on a load-use hazard, supports a flush from a taken branch or jump, and counts hazard bubbles. Don't-care control fields are driven to 0, never Z.

## Interface
- PC_W, 32: PC / target width; legal range 28..32.
- DATA_W, 32: width of the extended immediate; at least 16.
- CNT_W, 16: width of the bubble counter.
- HAZARD_EN, 1: 1 enables load-use interlock; 0 never stalls.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  address of in_inst.
- in_ready  out  1  stage accepts in_inst this cycle.
- flush  in  1  kill the held entry and any instruction presented this cycle.
- out_ready  in  1  execute consumes the output register.
- out_valid  out  1  output register holds a live instruction.
- regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch  out  1 each  execute control.
- alusig  out  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 6 slt.
- rs, rt, rd  out  5 each  register fields inst[25:21], [20:16], [15:11].
- imm  out  DATA_W  inst[15:0]; sign-extended when extop=1, zero-extended when extop=0.
- br_target  out  PC_W  in_pc + 4 + (sext(inst[15:0]) << 2), truncated to PC_W.
- j_target  out  PC_W  {(in_pc+4)[PC_W-1:28], inst[25:0], 2'b00}.
- out_pc  out  PC_W  registered in_pc.
- illegal  out  1  opcode/funct not in the decode list.
- bubble_cnt  out  CNT_W  saturating count of inserted hazard bubbles.

## Operation
- Decode list, as regdst/regwr/extop/alusrc/memwr/memtoreg/jump/branch and alusig:
  - opcode 000000: regdst=1, regwr=1, alusrc=0. funct selects alusig: 100000 add→0, 100010 sub→1, 100100 and→2, 100101 or→3, 101010 slt→6.
  - 001000 addi: regwr=1, extop=1, alusrc=1, alusig=0.
  - 001100 andi: regwr=1, extop=0, alusrc=1, alusig=2.
  - 001101 ori: regwr=1, extop=0, alusrc=1, alusig=3.
  - 001010 slti: regwr=1, extop=1, alusrc=1, alusig=6.
  - 100011 lw: regwr=1, extop=1, alusrc=1, memtoreg=1, alusig=0.
  - 101011 sw: memwr=1, extop=1, alusrc=1, alusig=0.
  - 000100 beq: branch=1, extop=1, alusig=1.
  - 000010 j: jump=1.
  - Anything else, including an unlisted funct: illegal=1 and all control bits 0. The entry still flows with out_valid=1; the trap is handled downstream.
- Transfer rule: the output register loads when in_valid && in_ready.
- in_ready = (!out_valid || out_ready) && !hazard.
- hazard condition (only when HAZARD_EN=1):
  - held entry is valid lw with rt != 0, and the incoming instruction is valid, and
  - held rt == incoming rs for any non-j opcode, or held rt == incoming rt for R-type, sw or beq.
- Hazard with out_ready=1: the lw leaves and the register loads a bubble (out_valid=0); bubble_cnt increments.
- Next cycle hazard is clear and the waiting instruction is accepted, so the penalty is exactly one bubble.
- Hazard with out_ready=0: hold; no count.
- flush=1 has priority over everything:
  - next cycle out_valid=0;
  - in_ready=1 and the presented instruction is dropped;
  - no bubble is counted.
- bubble_cnt saturates at all-ones.

## Timing
- Latency is 1 cycle: an instruction accepted on edge N is visible on outputs after edge N.
- Output register holds stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready, hazard and flush; it never depends on in_valid except through the hazard compare.
- Reset (rst=1 at an edge): out_valid=0, every control output 0, rs/rt/rd/imm/targets/out_pc 0, illegal=0, bubble_cnt=0.
- rst overrides flush and any transfer; an instruction in flight at reset is lost.
- Flush and a hazard in the same cycle: the flush wins and no bubble is counted.
- PC arithmetic wraps modulo 2^PC_W.

## Test plan
- add $3,$1,$2 (0x00221820), out_ready=1 → next cycle out_valid=1, regdst=1, regwr=1, alusig=0, rs=1, rt=2, rd=3, illegal=0.
- addi $5,$2,-1 (0x2045FFFF), DATA_W=32 → imm=0xFFFFFFFF, extop=1. ori $5,$2,0xFFFF (0x3445FFFF) → imm=0x0000FFFF.
- beq $1,$2,+3 (0x10220003) at pc 0x100 → branch=1, alusig=1, br_target=0x110. j (0x08000040) at pc 0x00400000 → jump=1, j_target=0x00000100.
- lw $2,4($1) (0x8C220004) then add $3,$2,$4, out_ready=1 → one out_valid=0 cycle between them, in_ready=0 for one cycle, bubble_cnt=1. Repeat with HAZARD_EN=0 → no bubble, bubble_cnt=0.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged. Assert flush → next cycle out_valid=0, the presented instruction is never output.
- 0xFC000000 → illegal=1, all control bits 0. Assert rst mid-stream → all outputs 0 after the edge and bubble_cnt=0.
